// File: rtl/sequence_generator_if.sv
// Control and status bundle for the serial sequence generator.
// The master drives frame requests and pattern selection; the slave
// (the generator) drives the serial stream and its status flags.
// The frame-repeat request is named repeat_en because "repeat" is a
// reserved word in SystemVerilog.
interface sequence_generator_if #(
    parameter int PATTERN_LEN = 7
);
    logic                   start;
    logic                   repeat_en;
    logic                   pattern_sel;
    logic [PATTERN_LEN-1:0] pattern_in;
    logic                   serial_out;
    logic                   bit_strobe;
    logic                   busy;
    logic                   done;
    logic [2:0]             bit_index;
    logic [7:0]             frame_count;
    logic [9:0]             LEDR;

    modport master (
        output start, repeat_en, pattern_sel, pattern_in,
        input  serial_out, bit_strobe, busy, done, bit_index, frame_count, LEDR
    );

    modport slave (
        input  start, repeat_en, pattern_sel, pattern_in,
        output serial_out, bit_strobe, busy, done, bit_index, frame_count, LEDR
    );
endinterface

// File: rtl/sequence_generator.sv
// Serial sequence generator: transmits a PATTERN_LEN-bit pattern MSB first,
// each bit held for CLKS_PER_BIT clocks, with a sample strobe in the last
// cycle of every bit period, a done pulse per frame, a saturating frame
// counter and a 10-bit history of emitted bits.
module sequence_generator #(
    parameter int                     PATTERN_LEN     = 7,
    parameter int                     CLKS_PER_BIT    = 4,
    parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 7'b1100111
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    sequence_generator_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(PATTERN_LEN - 1);
    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

    state_t                 state_reg;
    logic [PATTERN_LEN-1:0] shift_reg;
    logic [7:0]             cnt_reg;
    logic                   serial_out_reg;
    logic                   bit_strobe_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [2:0]             bit_index_reg;
    logic [7:0]             frame_count_reg;
    logic [9:0]             ledr_reg;

    logic [PATTERN_LEN-1:0] sel_pattern;

    // Per-bit pattern source selection (default pattern or user pattern).
    generate
        for (genvar gi = 0; gi < PATTERN_LEN; gi++) begin : g_sel
            assign sel_pattern[gi] = bus.pattern_sel ? bus.pattern_in[gi]
                                                     : DEFAULT_PATTERN[gi];
        end
    endgenerate

    assign bus.serial_out  = serial_out_reg;
    assign bus.bit_strobe  = bit_strobe_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.bit_index   = bit_index_reg;
    assign bus.frame_count = frame_count_reg;
    assign bus.LEDR        = ledr_reg;

    // Frame FSM with all outputs registered. A frame load (from IDLE or a
    // back-to-back repeat) puts the MSB on serial_out on the loading edge;
    // the strobe is asserted one edge ahead so it coincides with the
    // counter sitting at its last value.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            cnt_reg         <= '0;
            serial_out_reg  <= 1'b0;
            bit_strobe_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            bit_index_reg   <= '0;
            frame_count_reg <= '0;
            ledr_reg        <= '0;
        end else begin
            done_reg       <= 1'b0;
            bit_strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    serial_out_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    if (bus.start) begin
                        state_reg      <= SHIFT;
                        shift_reg      <= sel_pattern;
                        serial_out_reg <= sel_pattern[PATTERN_LEN-1];
                        cnt_reg        <= '0;
                        bit_index_reg  <= LAST_IDX;
                        busy_reg       <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (cnt_reg == CNT_LAST) begin
                        // End of a bit period: record the bit just sent.
                        ledr_reg <= {ledr_reg[8:0], serial_out_reg};
                        cnt_reg  <= '0;
                        if (bit_index_reg == 3'd0) begin
                            done_reg <= 1'b1;
                            if (frame_count_reg != 8'hFF) begin
                                frame_count_reg <= frame_count_reg + 8'd1;
                            end
                            if (bus.repeat_en) begin
                                // Back-to-back frame: reload with no gap.
                                shift_reg      <= sel_pattern;
                                serial_out_reg <= sel_pattern[PATTERN_LEN-1];
                                bit_index_reg  <= LAST_IDX;
                            end else begin
                                state_reg      <= FINISH;
                                serial_out_reg <= 1'b0;
                            end
                        end else begin
                            shift_reg      <= shift_reg << 1;
                            serial_out_reg <= shift_reg[PATTERN_LEN-2];
                            bit_index_reg  <= bit_index_reg - 3'd1;
                        end
                    end else begin
                        cnt_reg        <= cnt_reg + 8'd1;
                        bit_strobe_reg <= ((cnt_reg + 8'd1) == CNT_LAST);
                    end
                end

                FINISH: begin
                    state_reg      <= IDLE;
                    busy_reg       <= 1'b0;
                    serial_out_reg <= 1'b0;
                end

                default: begin
                    state_reg      <= IDLE;
                    busy_reg       <= 1'b0;
                    serial_out_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: stimulus pushes expected strobed
// bits and expected frame completions; a monitor pops and compares them
// whenever the DUT raises bit_strobe or done.
module tb_sequence_generator;
    localparam int L   = 7;
    localparam int CPB = 4;
    localparam logic [6:0] DEF = 7'b1100111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sequence_generator_if #(.PATTERN_LEN(L)) bus ();

    sequence_generator #(
        .PATTERN_LEN    (L),
        .CLKS_PER_BIT   (CPB),
        .DEFAULT_PATTERN(DEF)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        logic       b;
        logic [2:0] idx;
        int         e;
    } strobe_t;

    typedef struct {
        int         e;
        logic [7:0] fc;
        logic [9:0] ledr;
    } done_t;

    strobe_t sq[$];
    done_t   dq[$];
    int      edge_cnt = 0;
    int      checks   = 0;
    int      failures = 0;
    bit      expect_busy = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: compare every strobe and every done against the scoreboard.
    always @(negedge clk) begin : monitor
        strobe_t s;
        done_t   d;
        if (bus.bit_strobe) begin
            if (sq.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                s = sq.pop_front();
                chk("strobe_bit", int'(bus.serial_out), int'(s.b));
                chk("strobe_index", int'(bus.bit_index), int'(s.idx));
                chk("strobe_edge", edge_cnt, s.e);
                $display("strobe edge=%0d idx=%0d bit=%0d", edge_cnt, bus.bit_index, bus.serial_out);
            end
        end
        if (bus.done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                d = dq.pop_front();
                chk("done_edge", edge_cnt, d.e);
                chk("frame_count", int'(bus.frame_count), int'(d.fc));
                chk("ledr", int'(bus.LEDR), int'(d.ledr));
                $display("done edge=%0d frame_count=%0d LEDR=%b", edge_cnt, bus.frame_count, bus.LEDR);
            end
        end
        if (expect_busy) chk("busy_held", int'(bus.busy), 1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) step();
    endtask

    task automatic push_frame(input int s, input logic [6:0] pat,
                              input logic [7:0] fc, input logic [9:0] ledr);
        for (int i = 0; i < L; i++) begin
            sq.push_back('{pat[L-1-i], 3'(L-1-i), s + (CPB-1) + CPB*i});
        end
        dq.push_back('{s + L*CPB, fc, ledr});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_serial_out"}, int'(bus.serial_out), 0);
        chk({tag, "_bit_strobe"}, int'(bus.bit_strobe), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_bit_index"}, int'(bus.bit_index), 0);
        chk({tag, "_frame_count"}, int'(bus.frame_count), 0);
        chk({tag, "_ledr"}, int'(bus.LEDR), 0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_drained"}, sq.size() + dq.size(), 0);
        sq.delete();
        dq.delete();
    endtask

    int s;

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.repeat_en   = 1'b0;
        bus.pattern_sel = 1'b0;
        bus.pattern_in  = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Default pattern, single-cycle start.
        bus.start = 1'b1;
        s = edge_cnt + 1;
        push_frame(s, DEF, 8'd1, 10'b0001100111);
        step();
        bus.start = 1'b0;
        chk("t1_busy_after_start", int'(bus.busy), 1);
        chk("t1_msb", int'(bus.serial_out), 1);
        chk("t1_first_index", int'(bus.bit_index), 6);
        wait_until(s + 28);
        chk("t1_finish_busy", int'(bus.busy), 1);
        step();
        chk("t1_idle_busy", int'(bus.busy), 0);
        chk("t1_idle_serial", int'(bus.serial_out), 0);
        check_drained("t1");

        // User pattern; mid-frame pattern changes must be ignored.
        bus.pattern_sel = 1'b1;
        bus.pattern_in  = 7'b1010001;
        bus.start = 1'b1;
        s = edge_cnt + 1;
        push_frame(s, 7'b1010001, 8'd2, 10'b1111010001);
        step();
        bus.start = 1'b0;
        wait_until(s + 9);
        bus.pattern_in  = 7'b0101110;
        bus.pattern_sel = 1'b0;
        wait_until(s + 29);
        chk("t2_idle_busy", int'(bus.busy), 0);
        check_drained("t2");

        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Repeat mode: three back-to-back frames.
        bus.repeat_en = 1'b1;
        bus.start = 1'b1;
        s = edge_cnt + 1;
        push_frame(s,      DEF, 8'd1, 10'b0001100111);
        push_frame(s + 28, DEF, 8'd2, 10'b1111100111);
        push_frame(s + 56, DEF, 8'd3, 10'b1111100111);
        step();
        bus.start = 1'b0;
        expect_busy = 1'b1;
        wait_until(s + 60);
        bus.repeat_en = 1'b0;
        wait_until(s + 84);
        expect_busy = 1'b0;
        step();
        chk("t3_idle_busy", int'(bus.busy), 0);
        check_drained("t3");

        // Reset at cycle 10 of a frame, then reset together with start.
        bus.start = 1'b1;
        s = edge_cnt + 1;
        sq.push_back('{1'b1, 3'd6, s + 3});
        sq.push_back('{1'b1, 3'd5, s + 7});
        step();
        bus.start = 1'b0;
        wait_until(s + 9);
        reset = 1'b1;
        step();
        check_reset_outputs("midreset");
        bus.start = 1'b1;
        step();
        chk("reset_over_start_busy", int'(bus.busy), 0);
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (40) step();
        chk("no_resume_busy", int'(bus.busy), 0);
        chk("no_resume_frame_count", int'(bus.frame_count), 0);
        check_drained("t4");

        // Start held through a frame: exactly one extra frame after FINISH/IDLE.
        bus.start = 1'b1;
        s = edge_cnt + 1;
        push_frame(s,      DEF, 8'd1, 10'b0001100111);
        push_frame(s + 30, DEF, 8'd2, 10'b1111100111);
        step();
        wait_until(s + 35);
        bus.start = 1'b0;
        wait_until(s + 58);
        chk("t5_finish_busy", int'(bus.busy), 1);
        step();
        chk("t5_idle_busy", int'(bus.busy), 0);
        repeat (40) step();
        chk("t5_stays_idle", int'(bus.busy), 0);
        check_drained("t5");

        // Saturation: 256 back-to-back frames, counter must stop at 255.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.repeat_en = 1'b1;
        bus.start = 1'b1;
        s = edge_cnt + 1;
        for (int k = 1; k <= 256; k++) begin
            push_frame(s + 28*(k-1), DEF, (k > 255) ? 8'd255 : 8'(k),
                       (k == 1) ? 10'b0001100111 : 10'b1111100111);
        end
        step();
        bus.start = 1'b0;
        wait_until(s + 28*255 + 5);
        bus.repeat_en = 1'b0;
        wait_until(s + 28*256 + 1);
        chk("t6_idle_busy", int'(bus.busy), 0);
        chk("t6_saturated", int'(bus.frame_count), 255);
        check_drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The block SHALL have parameter PATTERN_LEN, default 7, giving the number of serial bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles per bit period (legal 2..255).
REQ-003 The block SHALL have parameter DEFAULT_PATTERN, default 7'b1100111, as the pattern used when pattern_sel=0.
REQ-004 CLOCK_50  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on the rising edge of CLOCK_50.
REQ-006 start  in  1  request to begin one frame; level-sampled in IDLE only.
REQ-007 repeat  in  1  when high at the end of a frame, the next frame starts with no gap.
REQ-008 pattern_sel  in  1  0 = DEFAULT_PATTERN, 1 = pattern_in.
REQ-009 pattern_in  in  PATTERN_LEN  user pattern, transmitted MSB first.
REQ-010 serial_out  out  1  current transmitted bit; 0 when idle.
REQ-011 bit_strobe  out  1  one-cycle pulse in the last cycle of each bit period (the receiver's sample point).
REQ-012 busy  out  1  high while a frame is in progress.
REQ-013 done  out  1  one-cycle pulse after the final bit period of each frame.
REQ-014 bit_index  out  3  index of the bit currently on serial_out (PATTERN_LEN-1 down to 0).
REQ-015 frame_count  out  8  number of completed frames, saturating.
REQ-016 LEDR  out  10  history of emitted bits; newest bit in LEDR[0].

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and FINISH.
REQ-018 In IDLE with start=1, the block SHALL on the same edge latch the selected pattern into a shift register and enter SHIFT.
- Same edge: busy=1, bit_index=PATTERN_LEN-1, serial_out=pattern MSB, prescale counter=0.
REQ-019 In SHIFT, the prescale counter SHALL count 0..CLKS_PER_BIT-1, and serial_out SHALL stay constant for exactly CLKS_PER_BIT cycles per bit.
REQ-020 bit_strobe SHALL be 1 exactly when the counter equals CLKS_PER_BIT-1.
- On that edge: LEDR shifts left with serial_out inserted at LEDR[0].
- The counter returns to 0 and the next bit (MSB-first order) drives serial_out, with bit_index decremented.
REQ-021 After the strobe of bit_index=0, the block SHALL enter FINISH: done=1 for one cycle and frame_count incremented, saturating at 255.
REQ-022 In FINISH with repeat=0, the block SHALL go to IDLE on the next edge (busy=0, serial_out=0).
- FINISH therefore holds busy=1 for one cycle.
REQ-023 Repeat mode SHALL run back-to-back frames with no gap.
- Condition: repeat=1 sampled on the final strobe cycle.
- done still pulses, but the FSM bypasses FINISH and reloads the pattern (re-sampling pattern_sel/pattern_in) on the same edge.
- busy stays 1 and the next frame's MSB appears on the cycle immediately after the final bit period.
REQ-024 Changes to start, pattern_sel or pattern_in while busy SHALL be ignored.
REQ-025 Start-to-done latency SHALL be PATTERN_LEN*CLKS_PER_BIT cycles, measured from the start edge to the cycle in which done=1.
REQ-026 With the defaults, the bit sequence presented on successive strobes SHALL be 1,1,0,0,1,1,1, i.e. the order a serial 1100111 detector expects.
REQ-027 The block SHALL treat start=1 held continuously while idle as a new start on the first edge it is in IDLE.

Reset
REQ-028 reset=1 SHALL override all other inputs, including mid-frame, and on that edge force:
- state=IDLE, serial_out=0, bit_strobe=0, busy=0, done=0
- bit_index=0, prescale counter=0, frame_count=0, LEDR=0
REQ-029 No partial frame SHALL resume after reset is released; a new start is required.
REQ-030 Reset SHALL take priority over a simultaneous start.

Verification
REQ-031 Defaults, pulse start for 1 cycle -> serial_out = 1,1,0,0,1,1,1, each held 4 cycles; 7 strobes; done at cycle 28; frame_count=1; LEDR=10'b0001100111.
REQ-032 pattern_sel=1, pattern_in=7'b1010001, start -> strobed bits 1,0,1,0,0,0,1; changing pattern_in mid-frame has no effect.
REQ-033 repeat=1, start once, run 3 frames -> no idle cycle between frames; done pulses at cycles 28, 56, 84; busy never drops; frame_count=3.
REQ-034 Assert reset at cycle 10 of a frame -> next cycle all outputs at reset values; no done; frame_count unchanged at 0.
REQ-035 start=1 held while busy, repeat=0 -> exactly one extra frame, starting after the FINISH→IDLE cycle.
REQ-036 Force frame_count to 255 via 255 repeat frames, then one more frame -> frame_count stays 255.
